// File: rtl/vector_mem_unit_if.sv
// Signal bundle between the vector load/store unit, the issue stage,
// data memory and the vector register-file write port.
interface vector_mem_unit_if #(
    parameter int VLEN   = 192,
    parameter int MEM_W  = 32,
    parameter int ADDR_W = 32
);
    logic              start;
    logic              is_store;
    logic [ADDR_W-1:0] base_addr;
    logic [3:0]        vd;
    logic [VLEN-1:0]   store_data;

    logic [MEM_W-1:0]  mem_rdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [MEM_W-1:0]  mem_wdata;

    logic              busy;
    logic              done;
    logic              err;

    logic              rf_wr_enable;
    logic [3:0]        rf_rd;
    logic [VLEN-1:0]   rf_wd;

    // master is the unit itself; slave is everything around it
    modport master (
        input  start, is_store, base_addr, vd, store_data, mem_rdata, mem_ready,
        output busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output rf_wr_enable, rf_rd, rf_wd
    );

    modport slave (
        output start, is_store, base_addr, vd, store_data, mem_rdata, mem_ready,
        input  busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  rf_wr_enable, rf_rd, rf_wd
    );
endinterface

// File: rtl/vector_mem_unit.sv
// Vector load/store unit: moves one VLEN-bit vector register to or from
// memory as BEATS consecutive MEM_W-bit words, one handshake per word.
module vector_mem_unit #(
    parameter int VLEN   = 192,
    parameter int MEM_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    vector_mem_unit_if.master  bus
);
    localparam int BEATS  = VLEN / MEM_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int OFF_W  = $clog2(MEM_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(MEM_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WB,
        DONE
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic                         is_store_q;
    logic [ADDR_W-1:0]            base_q;
    logic [3:0]                   vd_q;
    logic [BEATS-1:0][MEM_W-1:0]  vec_q;
    logic [BEAT_W-1:0]            beat;
    logic                         err_q;
    logic                         cmd_bad;
    logic                         last_beat;
    logic                         beat_done;

    // Misaligned base or an out-of-range load destination short-circuits to DONE
    assign cmd_bad   = (bus.base_addr[OFF_W-1:0] != '0) ||
                       (!bus.is_store && (bus.vd >= 4'd8));
    assign last_beat = (beat == LAST_BEAT);
    assign beat_done = (state == XFER) && bus.mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        bus.err          = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_rd_en    = 1'b0;
        bus.mem_wr_en    = 1'b0;
        bus.mem_wdata    = '0;
        bus.rf_wr_enable = 1'b0;
        bus.rf_rd        = '0;
        bus.rf_wd        = '0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = cmd_bad ? DONE : XFER;
                end
            end
            XFER: begin
                bus.busy     = 1'b1;
                bus.mem_addr = base_q + ADDR_W'(beat) * BEAT_BYTES;
                if (is_store_q) begin
                    bus.mem_wr_en = 1'b1;
                    bus.mem_wdata = vec_q[beat];
                end else begin
                    bus.mem_rd_en = 1'b1;
                end
                if (bus.mem_ready && last_beat) begin
                    state_next = is_store_q ? DONE : WB;
                end
            end
            WB: begin
                bus.busy         = 1'b1;
                bus.rf_wr_enable = 1'b1;
                bus.rf_rd        = vd_q;
                bus.rf_wd        = vec_q;
                state_next       = DONE;
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                bus.err    = err_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The same buffer holds the store operand or collects the load lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            base_q     <= '0;
            vd_q       <= '0;
            vec_q      <= '0;
            beat       <= '0;
            err_q      <= 1'b0;
        end else if ((state == IDLE) && bus.start) begin
            is_store_q <= bus.is_store;
            base_q     <= bus.base_addr;
            vd_q       <= bus.vd;
            vec_q      <= bus.store_data;
            beat       <= '0;
            err_q      <= cmd_bad;
        end else if (beat_done) begin
            if (!is_store_q) begin
                vec_q[beat] <= bus.mem_rdata;
            end
            if (!last_beat) begin
                beat <= beat + BEAT_W'(1);
            end
        end
    end
endmodule
